// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared constants and types for the Pmod DA2 (DAC121S101) SPI driver.
//   FRAME_BITS : bits per SPI frame sent to the DAC
//   DATA_BITS  : width of one DAC sample
//   state_t    : driver FSM states
//   PD_*       : DAC power-down codes placed in frame bits [13:12]
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

endpackage

// File: rtl/dac_sclk_tick.sv
// -----------------------------------------------------------------------------
// dac_sclk_tick
// SCLK phase timer. Splits each serial bit into a high half and a low half of
// CLK_DIV clock cycles each and flags the last cycle of each half.
//   i_clk       : system clock
//   i_rst       : asynchronous active-high reset
//   i_en        : run enable; while low the timer is held at the start of a bit
//   o_fall_tick : last cycle of the high half (SCLK falls on the next edge)
//   o_rise_tick : last cycle of the low half, i.e. the bit boundary
// -----------------------------------------------------------------------------
module dac_sclk_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_fall_tick,
    output logic o_rise_tick
);

    localparam int unsigned     CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_low;     // 0 = high half of the bit, 1 = low half
    logic          w_half_end;

    assign w_half_end  = i_en && (r_cnt == LAST);
    assign o_fall_tick = w_half_end && !r_low;
    assign o_rise_tick = w_half_end &&  r_low;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_low <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_low <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_low <= ~r_low;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_driver.sv
// -----------------------------------------------------------------------------
// dac_spi_driver
// Serialises 12-bit samples into 16-bit SPI frames {2'b00, PD_MODE, SAMPLE}
// for the Pmod DA2, MSB first, with a one-deep pending buffer.
//   CLK, RESET   : system clock, asynchronous active-high reset
//   SAMPLE       : unsigned sample, SAMPLE_VALID one-cycle strobe
//   SAMPLE_READY : pending buffer empty (accept on VALID && READY)
//   SYNC_N, SCLK, DINA : DAC serial interface (SCLK idles high)
//   BUSY         : frame or inter-frame gap in progress
//   FRAME_DONE   : one-cycle pulse when the gap ends
//   DROP         : one-cycle pulse after a VALID that arrived while not ready
// Build option: define DAC_DUAL_CHANNEL_EN to add SAMPLE_B / DINB, a second
// data lane shifted in lockstep with DINA on the shared SYNC_N / SCLK.
// -----------------------------------------------------------------------------
module dac_spi_driver
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned GAP_BITS = 1,
    parameter logic [1:0]  PD_MODE  = PD_NORMAL
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] SAMPLE,
`ifdef DAC_DUAL_CHANNEL_EN
    input  logic [DATA_BITS-1:0] SAMPLE_B,
    output logic                 DINB,
`endif
    input  logic                 SAMPLE_VALID,
    output logic                 SAMPLE_READY,
    output logic                 SYNC_N,
    output logic                 SCLK,
    output logic                 DINA,
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic                 DROP
);

    localparam int unsigned     GW       = $clog2(GAP_BITS + 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_BITS - 1);
    localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

    state_t                  r_state, w_state_next;
    logic [DATA_BITS-1:0]    r_sample;
    logic                    r_full;
    logic                    r_drop;
    logic                    r_sync_n, w_sync_n_next;
    logic                    r_sclk, w_sclk_next;
    logic                    r_dina, w_dina_next;
    logic                    r_done, w_done_next;
    logic [FRAME_BITS-1:0]   r_shift, w_shift_next;
    logic [3:0]              r_bit, w_bit_next;
    logic [GW-1:0]           r_gap, w_gap_next;
    logic                    w_drain;
    logic                    w_accept;
    logic                    w_fall_tick, w_rise_tick;
    logic [FRAME_BITS-1:0]   w_frame_a;

`ifdef DAC_DUAL_CHANNEL_EN
    logic [DATA_BITS-1:0]    r_sample_b;
    logic [FRAME_BITS-1:0]   r_shift_b, w_shift_b_next;
    logic                    r_dinb, w_dinb_next;
    logic [FRAME_BITS-1:0]   w_frame_b;

    assign w_frame_b = {2'b00, PD_MODE, r_sample_b};
    assign DINB      = r_dinb;
`endif

    assign w_frame_a    = {2'b00, PD_MODE, r_sample};
    // READY reflects the registered full flag, so a drain and an accept can
    // never collide on a stale buffer.
    assign w_accept     = SAMPLE_VALID && !r_full;

    assign SAMPLE_READY = !r_full;
    assign SYNC_N       = r_sync_n;
    assign SCLK         = r_sclk;
    assign DINA         = r_dina;
    assign BUSY         = (r_state != IDLE);
    assign FRAME_DONE   = r_done;
    assign DROP         = r_drop;

    // The timer also paces the gap, which is measured in whole SCLK periods.
    dac_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_en        (r_state != IDLE),
        .o_fall_tick (w_fall_tick),
        .o_rise_tick (w_rise_tick)
    );

    // Pending buffer and drop reporting.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sample <= '0;
            r_full   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= SAMPLE_VALID && r_full;
            if (w_accept) begin
                r_sample <= SAMPLE;
                r_full   <= 1'b1;
            end else if (w_drain) begin
                r_full   <= 1'b0;
            end
        end
    end

`ifdef DAC_DUAL_CHANNEL_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sample_b <= '0;
        end else if (w_accept) begin
            r_sample_b <= SAMPLE_B;
        end
    end
`endif

    // FSM state and serial output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_sync_n <= 1'b1;
            r_sclk   <= 1'b1;
            r_dina   <= 1'b0;
            r_done   <= 1'b0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_gap    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_sync_n <= w_sync_n_next;
            r_sclk   <= w_sclk_next;
            r_dina   <= w_dina_next;
            r_done   <= w_done_next;
            r_shift  <= w_shift_next;
            r_bit    <= w_bit_next;
            r_gap    <= w_gap_next;
        end
    end

`ifdef DAC_DUAL_CHANNEL_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_shift_b <= '0;
            r_dinb    <= 1'b0;
        end else begin
            r_shift_b <= w_shift_b_next;
            r_dinb    <= w_dinb_next;
        end
    end
`endif

    always_comb begin
        w_state_next  = r_state;
        w_sync_n_next = r_sync_n;
        w_sclk_next   = r_sclk;
        w_dina_next   = r_dina;
        w_done_next   = 1'b0;
        w_shift_next  = r_shift;
        w_bit_next    = r_bit;
        w_gap_next    = r_gap;
        w_drain       = 1'b0;
`ifdef DAC_DUAL_CHANNEL_EN
        w_shift_b_next = r_shift_b;
        w_dinb_next    = r_dinb;
`endif
        case (r_state)
            IDLE: begin
                if (r_full) begin
                    // Bit 15 is presented together with the SYNC_N fall; SCLK
                    // is already high, so the first DAC sample is the coming fall.
                    w_drain       = 1'b1;
                    w_shift_next  = w_frame_a;
                    w_dina_next   = w_frame_a[FRAME_BITS-1];
                    w_sync_n_next = 1'b0;
                    w_sclk_next   = 1'b1;
                    w_bit_next    = '0;
                    w_state_next  = SHIFT;
`ifdef DAC_DUAL_CHANNEL_EN
                    w_shift_b_next = w_frame_b;
                    w_dinb_next    = w_frame_b[FRAME_BITS-1];
`endif
                end
            end
            SHIFT: begin
                if (w_fall_tick) begin
                    w_sclk_next = 1'b0;
                end else if (w_rise_tick) begin
                    w_sclk_next = 1'b1;
                    if (r_bit == BIT_LAST) begin
                        w_sync_n_next = 1'b1;
                        w_dina_next   = 1'b0;
                        w_gap_next    = '0;
                        w_state_next  = GAP;
`ifdef DAC_DUAL_CHANNEL_EN
                        w_dinb_next   = 1'b0;
`endif
                    end else begin
                        // DINA only moves on SCLK rising edges.
                        w_shift_next = r_shift << 1;
                        w_dina_next  = r_shift[FRAME_BITS-2];
                        w_bit_next   = r_bit + 4'd1;
`ifdef DAC_DUAL_CHANNEL_EN
                        w_shift_b_next = r_shift_b << 1;
                        w_dinb_next    = r_shift_b[FRAME_BITS-2];
`endif
                    end
                end
            end
            GAP: begin
                if (w_rise_tick) begin
                    if (r_gap == GAP_LAST) begin
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_gap_next = r_gap + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_spi_driver.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_driver
// Directed bench for dac_spi_driver. u0 uses the default build parameters
// (CLK_DIV=2, GAP_BITS=1, PD_MODE=00); u1 uses CLK_DIV=1, GAP_BITS=2,
// PD_MODE=11. A select bit routes one instance to the monitor signals.
// Optional DAC_DUAL_CHANNEL_EN adds the channel B ports and the B-lane check.
// -----------------------------------------------------------------------------
module tb_dac_spi_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] s0, s1;
    logic        v0, v1;
    logic        sel;

    logic ready0, sync0, sclk0, dina0, busy0, done0, drop0;
    logic ready1, sync1, sclk1, dina1, busy1, done1, drop1;
    logic m_ready, m_sync, m_sclk, m_dina, m_busy, m_done, m_drop;

    int n_cmp = 0;
    int n_err = 0;
    int drop_cnt = 0;

`ifdef DAC_DUAL_CHANNEL_EN
    logic [11:0] sb0, sb1;
    logic        dinb0, dinb1, m_dinb;
    assign m_dinb = sel ? dinb1 : dinb0;
`endif

    always #5 clk = ~clk;

    assign m_ready = sel ? ready1 : ready0;
    assign m_sync  = sel ? sync1  : sync0;
    assign m_sclk  = sel ? sclk1  : sclk0;
    assign m_dina  = sel ? dina1  : dina0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_drop  = sel ? drop1  : drop0;

    always @(negedge clk) if (m_drop === 1'b1) drop_cnt <= drop_cnt + 1;

    dac_spi_driver u0 (
        .CLK          (clk),
        .RESET        (rst),
        .SAMPLE       (s0),
`ifdef DAC_DUAL_CHANNEL_EN
        .SAMPLE_B     (sb0),
        .DINB         (dinb0),
`endif
        .SAMPLE_VALID (v0),
        .SAMPLE_READY (ready0),
        .SYNC_N       (sync0),
        .SCLK         (sclk0),
        .DINA         (dina0),
        .BUSY         (busy0),
        .FRAME_DONE   (done0),
        .DROP         (drop0)
    );

    dac_spi_driver #(
        .CLK_DIV  (1),
        .GAP_BITS (2),
        .PD_MODE  (2'b11)
    ) u1 (
        .CLK          (clk),
        .RESET        (rst),
        .SAMPLE       (s1),
`ifdef DAC_DUAL_CHANNEL_EN
        .SAMPLE_B     (sb1),
        .DINB         (dinb1),
`endif
        .SAMPLE_VALID (v1),
        .SAMPLE_READY (ready1),
        .SYNC_N       (sync1),
        .SCLK         (sclk1),
        .DINA         (dina1),
        .BUSY         (busy1),
        .FRAME_DONE   (done1),
        .DROP         (drop1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle VALID strobe; returns at the sample point after the accept edge.
    task automatic pulse(input logic which, input logic [11:0] d, input logic [11:0] db);
        if (which) begin s1 = d; v1 = 1'b1; end
        else       begin s0 = d; v0 = 1'b1; end
`ifdef DAC_DUAL_CHANNEL_EN
        if (which) sb1 = db; else sb0 = db;
`else
        if (db != 12'h000) $display("note: channel B data ignored in this build");
`endif
        step(1);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    // Waits for SYNC_N low, records DINA/DINB at each SCLK fall while SYNC_N is
    // low, then counts cycles from the SYNC_N rise until FRAME_DONE is seen.
    task automatic get_frame(output logic [15:0] a, output logic [15:0] b,
                             output int wait_n, output int low, output int gap,
                             output int toggles, output bit to);
        logic prev;
        a = '0; b = '0; wait_n = 0; low = 0; gap = 0; toggles = 0; to = 1'b0;
        while (m_sync !== 1'b0 && wait_n < 300) begin
            step(1);
            wait_n++;
        end
        if (wait_n >= 300) begin
            to = 1'b1;
            return;
        end
        prev = m_sclk;
        while (m_sync === 1'b0 && low < 300) begin
            if (prev !== m_sclk) toggles++;
            if (prev === 1'b1 && m_sclk === 1'b0) begin
                a = {a[14:0], m_dina};
`ifdef DAC_DUAL_CHANNEL_EN
                b = {b[14:0], m_dinb};
`endif
            end
            prev = m_sclk;
            low++;
            step(1);
        end
        while (m_done !== 1'b1 && gap < 300) begin
            gap++;
            step(1);
        end
        if (low >= 300 || gap >= 300) to = 1'b1;
    endtask

    logic [15:0] fa, fb;
    int wn, lo, gp, tg, d0;
    bit to;

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; s0 = '0; s1 = '0; sel = 1'b0;
`ifdef DAC_DUAL_CHANNEL_EN
        sb0 = '0; sb1 = '0;
`endif
        step(2);
        check("rst_sync_n", m_sync, 1);
        check("rst_sclk",   m_sclk, 1);
        check("rst_dina",   m_dina, 0);
        check("rst_busy",   m_busy, 0);
        check("rst_ready",  m_ready, 1);
        check("rst_done",   m_done, 0);
        check("rst_drop",   m_drop, 0);
        rst = 1'b0;
        step(2);

        // Single sample 0xA5C, CLK_DIV=2.
        pulse(1'b0, 12'hA5C, 12'h000);
        check("t1_ready_after_accept", m_ready, 0);
        check("t1_sync_still_high", m_sync, 1);
        step(1);
        check("t1_sync_low_next", m_sync, 0);
        check("t1_sclk_high_first", m_sclk, 1);
        check("t1_dina_bit15", m_dina, 0);
        check("t1_busy", m_busy, 1);
        get_frame(fa, fb, wn, lo, gp, tg, to);
        check("t1_timeout", {31'd0, to}, 0);
        check("t1_bits", fa, 16'h0A5C);
        check("t1_sync_low_cycles", lo, 64);
        check("t1_done_after_rise", gp, 4);
        check("t1_sclk_toggles", tg, 31);
        step(1);
        check("t1_done_one_cycle", m_done, 0);
        check("t1_idle_busy", m_busy, 0);

        // Two samples three cycles apart: 0x000 then 0xFFF.
        d0 = drop_cnt;
        pulse(1'b0, 12'h000, 12'h000);
        check("t2_ready_low", m_ready, 0);
        step(1);
        check("t2_ready_after_drain", m_ready, 1);
        step(1);
        pulse(1'b0, 12'hFFF, 12'h000);
        check("t2_second_accepted", m_ready, 0);
        get_frame(fa, fb, wn, lo, gp, tg, to);
        check("t2_f1_timeout", {31'd0, to}, 0);
        check("t2_f1_bits", fa, 16'h0000);
        get_frame(fa, fb, wn, lo, gp, tg, to);
        check("t2_f2_timeout", {31'd0, to}, 0);
        check("t2_f2_back_to_back", wn, 1);
        check("t2_f2_bits", fa, 16'h0FFF);
        check("t2_f2_low_cycles", lo, 64);
        check("t2_no_drop", drop_cnt - d0, 0);

        // Three samples during one frame: the later two are dropped.
        step(2);
        pulse(1'b0, 12'h111, 12'h000);
        step(3);
        d0 = drop_cnt;
        pulse(1'b0, 12'h222, 12'h000);
        check("t3_buffer_full", m_ready, 0);
        step(2);
        pulse(1'b0, 12'h333, 12'h000);
        check("t3_drop_pulse_a", m_drop, 1);
        step(2);
        pulse(1'b0, 12'h344, 12'h000);
        check("t3_drop_pulse_b", m_drop, 1);
        step(1);
        check("t3_drop_one_cycle", m_drop, 0);
        check("t3_drop_count", drop_cnt - d0, 2);
        get_frame(fa, fb, wn, lo, gp, tg, to);
        get_frame(fa, fb, wn, lo, gp, tg, to);
        check("t3_timeout", {31'd0, to}, 0);
        check("t3_next_bits", fa, 16'h0222);
        step(3);
        check("t3_nothing_more_busy", m_busy, 0);
        check("t3_nothing_more_sync", m_sync, 1);

        // Reset in the middle of a frame (low phase of bit 10, DINA=1).
        pulse(1'b0, 12'hFFF, 12'h000);
        step(1);
        step(22);
        check("t4_pre_sync", m_sync, 0);
        check("t4_pre_sclk", m_sclk, 0);
        check("t4_pre_dina", m_dina, 1);
        rst = 1'b1;
        #1;
        check("t4_async_sync", m_sync, 1);
        check("t4_async_sclk", m_sclk, 1);
        check("t4_async_dina", m_dina, 0);
        check("t4_async_ready", m_ready, 1);
        check("t4_async_busy", m_busy, 0);
        #2;
        rst = 1'b0;
        step(2);
        pulse(1'b0, 12'h3C3, 12'h000);
        step(1);
        get_frame(fa, fb, wn, lo, gp, tg, to);
        check("t4_timeout", {31'd0, to}, 0);
        check("t4_fresh_bits", fa, 16'h03C3);
        check("t4_fresh_low", lo, 64);

        // CLK_DIV=1, GAP_BITS=2, PD_MODE=11 instance.
        sel = 1'b1;
        step(1);
        pulse(1'b1, 12'h001, 12'h000);
        step(1);
        check("t5_sclk_high_first", m_sclk, 1);
        get_frame(fa, fb, wn, lo, gp, tg, to);
        check("t5_timeout", {31'd0, to}, 0);
        check("t5_bits", fa, 16'h3001);
        check("t5_low_cycles", lo, 32);
        check("t5_sclk_toggles", tg, 31);
        check("t5_gap_cycles", gp, 4);

`ifdef DAC_DUAL_CHANNEL_EN
        // Both lanes in lockstep on the default instance.
        sel = 1'b0;
        step(2);
        pulse(1'b0, 12'h123, 12'hEDC);
        step(1);
        get_frame(fa, fb, wn, lo, gp, tg, to);
        check("t6_timeout", {31'd0, to}, 0);
        check("t6_dina_bits", fa, 16'h0123);
        check("t6_dinb_bits", fb, 16'h0EDC);
        step(1);
        check("t6_dinb_idle", {31'd0, m_dinb}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
